// File: rtl/mult_dispatch.sv
// Operand FIFO feeding a handshaked external multiplier, one operation in flight,
// with a single registered result slot toward the consumer.
module mult_dispatch #(
    parameter int unsigned N     = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             mul_init,
    input  logic             mul_idle,
    input  logic             mul_valid,
    output logic [N-1:0]     mul_multiplicand,
    output logic [N-1:0]     mul_multiplier,
    input  logic [2*N-1:0]   mul_product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_product,
    output logic             busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    mem_a_q [DEPTH];
    logic [N-1:0]    mem_b_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic [N-1:0]    mcand_q, mcand_d;
    logic [N-1:0]    mplier_q, mplier_d;
    logic            out_valid_q, out_valid_d;
    logic [2*N-1:0]  out_product_q, out_product_d;

    logic full, empty, push, pop, load_ops, load_res;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    // The head is popped during ISSUE; it was already copied into the operand registers.
    assign pop      = (state_q == ISSUE);

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        load_ops = 1'b0;
        load_res = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Only issue when the result slot will be free by the time this product lands.
                if (!empty && mul_idle && (!out_valid_q || out_ready)) begin
                    state_d  = ISSUE;
                    load_ops = 1'b1;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mul_valid) begin
                    state_d  = IDLE;
                    load_res = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mcand_d       = load_ops ? mem_a_q[rptr_q] : mcand_q;
        mplier_d      = load_ops ? mem_b_q[rptr_q] : mplier_q;
        out_product_d = load_res ? mul_product : out_product_q;
        out_valid_d   = out_valid_q;
        if (load_res) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q       <= IDLE;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wptr_q] <= in_a;
            mem_b_q[wptr_q] <= in_b;
        end
    end

    assign mul_init         = (state_q == ISSUE);
    assign busy             = (state_q == WAIT);
    assign mul_multiplicand = mcand_q;
    assign mul_multiplier   = mplier_q;
    assign out_valid        = out_valid_q;
    assign out_product      = out_product_q;

endmodule

// File: tb/tb_mult_dispatch.sv
// Directed bench for mult_dispatch: the bench plays the multiplier and the consumer,
// and scores every delivered product against the value expected for each accepted pair.
module tb_mult_dispatch;

    localparam int unsigned N = 64;
    localparam int unsigned W = 2 * N;

    logic           clk = 1'b0;
    logic           reset_L;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a, in_b;
    logic           mul_init;
    logic           mul_idle;
    logic           mul_valid;
    logic [N-1:0]   mul_multiplicand, mul_multiplier;
    logic [W-1:0]   mul_product;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_product;
    logic           busy;

    always #5 clk = ~clk;

    mult_dispatch #(.N(N), .DEPTH(4)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_init         (mul_init),
        .mul_idle         (mul_idle),
        .mul_valid        (mul_valid),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_product      (out_product),
        .busy             (busy)
    );

    int           nvec = 0;
    int           nmis = 0;
    logic [W-1:0] expq [$];
    logic [W-1:0] cur_exp;
    int           pushes = 0;
    int           done = 0;
    int           inits = 0;
    bit           m_busy = 1'b0;
    bit           m_hold = 1'b0;
    bit           m_lat_rand = 1'b0;
    int           m_cnt = 0;
    int           m_lat = 0;
    logic [N-1:0] m_a, m_b;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [W-1:0] r;
        r = $signed(a) * $signed(b);
        return r;
    endfunction

    // Handshakes are scored at the falling edge; multiplier responses change 3ns after the rising edge.
    task automatic step();
        @(negedge clk);
        if (reset_L) begin
            if (in_valid && in_ready) begin
                expq.push_back(cur_exp);
                pushes++;
            end
            if (out_valid && out_ready) begin
                check("extra_result", (expq.size() > 0), 1);
                if (expq.size() > 0) check("result", out_product, expq.pop_front());
                done++;
            end
            if (mul_init) begin
                check("one_inflight", m_busy, 0);
                m_busy = 1'b1;
                m_a    = mul_multiplicand;
                m_b    = mul_multiplier;
                m_cnt  = m_lat_rand ? int'($urandom_range(0, 3)) : m_lat;
                inits++;
            end
        end
        @(posedge clk);
        #3;
        mul_valid = 1'b0;
        if (m_busy) begin
            if (m_cnt == 0) begin
                mul_valid   = 1'b1;
                mul_product = ref_mul(m_a, m_b);
                m_busy      = 1'b0;
            end else begin
                m_cnt--;
            end
        end
        mul_idle = !m_busy && !m_hold;
    endtask

    task automatic push_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic [W-1:0] e);
        int p;
        p        = pushes;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        cur_exp  = e;
        for (int k = 0; k < 50 && pushes == p; k++) step();
        in_valid = 1'b0;
        check("push_accept", pushes - p, 1);
    endtask

    task automatic drain(input string tag, input int target);
        for (int k = 0; k < 400 && done < target; k++) step();
        check(tag, done, target);
    endtask

    task automatic reset_checks(input string s);
        check({s, "_in_ready"}, in_ready, 1);
        check({s, "_mul_init"}, mul_init, 0);
        check({s, "_mcand"}, mul_multiplicand, 0);
        check({s, "_mplier"}, mul_multiplier, 0);
        check({s, "_out_valid"}, out_valid, 0);
        check({s, "_out_product"}, out_product, 0);
        check({s, "_busy"}, busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, got no summary, required finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] fill_exp [5];
        int           p0, d0, i0, k;
        bit           saw;

        fill_exp = '{128'd10, 128'd22, 128'd36, 128'd52, 128'd70};
        reset_L = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        mul_idle = 1'b1; mul_valid = 1'b0; mul_product = '0; cur_exp = '0;
        m_a = '0; m_b = '0;

        @(posedge clk); #3;
        reset_checks("rst");
        @(posedge clk); #3;
        reset_L = 1'b1;
        step();

        // Single op: 3 * -5
        m_lat = 2; out_ready = 1'b1; i0 = inits;
        push_one(64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
        check("t1_init_early", mul_init, 0);
        step();
        check("t1_init", mul_init, 1);
        check("t1_mcand", mul_multiplicand, 64'd3);
        check("t1_mplier", mul_multiplier, 64'hFFFF_FFFF_FFFF_FFFB);
        for (k = 0; k < 20 && !mul_valid; k++) begin
            step();
            check("t1_mcand_stable", mul_multiplicand, 64'd3);
            check("t1_mplier_stable", mul_multiplier, 64'hFFFF_FFFF_FFFF_FFFB);
        end
        check("t1_mul_valid", mul_valid, 1);
        check("t1_busy", busy, 1);
        check("t1_out_not_yet", out_valid, 0);
        step();
        check("t1_out_valid", out_valid, 1);
        check("t1_product", out_product, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1);
        check("t1_one_init", inits - i0, 1);
        check("t1_idle", busy, 0);
        step();
        check("t1_out_cleared", out_valid, 0);

        // Fill with the multiplier held busy
        m_hold = 1'b1; mul_idle = 1'b0; p0 = pushes; d0 = done; i0 = inits;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_a     = N'(i + 1);
            in_b     = N'(10 + i);
            cur_exp  = fill_exp[i];
            step();
            if (i < 3) check("t2_not_full", in_ready, 1);
            else       check("t2_full", in_ready, 0);
        end
        check("t2_pushes4", pushes - p0, 4);
        check("t2_no_init", inits - i0, 0);
        m_hold = 1'b0;
        for (int j = 0; j < 200 && done < d0 + 5; j++) begin
            step();
            if (pushes - p0 == 5) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("t2_pushes5", pushes - p0, 5);
        check("t2_done", done - d0, 5);

        // Backpressure on the result slot
        out_ready = 1'b0; m_lat = 1; d0 = done;
        push_one(64'd7, 64'd8, 128'd56);
        push_one(64'hFFFF_FFFF_FFFF_FFFE, 64'd9, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEE);
        for (k = 0; k < 30 && !out_valid; k++) step();
        check("t3_valid", out_valid, 1);
        check("t3_product", out_product, 128'd56);
        i0 = inits;
        repeat (6) begin
            step();
            check("t3_hold_product", out_product, 128'd56);
            check("t3_hold_valid", out_valid, 1);
            check("t3_no_init", mul_init, 0);
        end
        check("t3_no_init_count", inits - i0, 0);
        out_ready = 1'b1;
        for (k = 0; k < 2 && !mul_init; k++) step();
        check("t3_reissue", mul_init, 1);
        drain("t3_done", d0 + 2);

        // Extremes
        m_lat = 0; d0 = done;
        push_one(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                 128'h4000_0000_0000_0000_0000_0000_0000_0000);
        push_one(64'd0, 64'h0123_4567_89AB_CDEF, 128'd0);
        push_one(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, '1);
        push_one(64'h8000_0000_0000_0000, 64'd1, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000);
        push_one(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                 128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);
        drain("t4_done", d0 + 5);

        // Asynchronous reset mid-WAIT with two pairs queued
        m_lat = 15; out_ready = 1'b1; i0 = inits;
        push_one(64'd2, 64'd3, 128'd6);
        push_one(64'd4, 64'd5, 128'd20);
        push_one(64'd6, 64'd7, 128'd42);
        for (k = 0; k < 10 && !busy; k++) step();
        check("t5_busy", busy, 1);
        check("t5_in_ready", in_ready, 1);
        #1;
        reset_L = 1'b0;
        #1;
        reset_checks("t5");
        expq.delete();
        step();
        step();
        reset_L = 1'b1;
        saw = 1'b0;
        for (int j = 0; j < 30; j++) begin
            step();
            if (mul_valid) saw = 1'b1;
            check("t5_no_out", out_valid, 0);
        end
        check("t5_stray_seen", saw, 1);
        check("t5_empty", in_ready, 1);
        check("t5_no_reissue", inits - i0, 1);

        // Random traffic against the reference model
        m_lat_rand = 1'b1; p0 = pushes; d0 = done;
        for (int c = 0; c < 40000 && done < d0 + 1000; c++) begin
            if (pushes - p0 < 1000 && $urandom_range(0, 2) != 0) begin
                in_valid = 1'b1;
                in_a = {$urandom, $urandom};
                in_b = {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) in_a = 64'h8000_0000_0000_0000;
                if ($urandom_range(0, 7) == 0) in_b = '1;
                cur_exp = ref_mul(in_a, in_b);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        check("rnd_pushes", pushes - p0, 1000);
        check("rnd_done", done - d0, 1000);
        check("rnd_left", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/mult_dispatch.md
MULT_DISPATCH -- requirements
Module: mult_dispatch

Interface
REQ-001 Parameter N, default 64, operand width in bits; product width is 2N.
REQ-002 Parameter DEPTH, default 4, operand FIFO depth in entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  an operand pair is offered on in_a/in_b.
REQ-006 in_ready  output  1  the FIFO can accept a pair this cycle.
REQ-007 in_a  input  N  signed multiplicand.
REQ-008 in_b  input  N  signed multiplier.
REQ-009 mul_init  output  1  one-cycle start strobe to the multiplier.
REQ-010 mul_idle  input  1  the multiplier is ready to start.
REQ-011 mul_valid  input  1  one-cycle product-ready pulse from the multiplier.
REQ-012 mul_multiplicand  output  N  registered multiplicand to the multiplier.
REQ-013 mul_multiplier  output  N  registered multiplier to the multiplier.
REQ-014 mul_product  input  2N  signed product from the multiplier.
REQ-015 out_valid  output  1  out_product holds an undelivered result.
REQ-016 out_ready  input  1  the consumer accepts the result this cycle.
REQ-017 out_product  output  2N  signed result.
REQ-018 busy  output  1  a multiplication is in flight (state WAIT).

Function
REQ-019 The FIFO SHALL hold DEPTH operand pairs, in order; a push occurs on in_valid && in_ready.
REQ-020 in_ready SHALL equal !full, with no same-cycle pass-through when full and popping.
REQ-021 A simultaneous push and pop when the FIFO is neither full nor empty SHALL leave the occupancy unchanged.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH.
REQ-023 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-024 IDLE->ISSUE SHALL occur when the FIFO is non-empty, mul_idle=1, and (out_valid=0 or out_ready=1).
REQ-025 In ISSUE, for one cycle: mul_init=1, mul_multiplicand/mul_multiplier show the FIFO head (loaded on the IDLE->ISSUE edge), and the head is popped.
REQ-026 ISSUE SHALL always transition to WAIT on the next edge.
REQ-027 In WAIT, mul_multiplicand and mul_multiplier SHALL stay stable.
REQ-028 In WAIT, on mul_valid=1 the block SHALL load out_product<=mul_product, set out_valid<=1, and return to IDLE.
REQ-029 WAIT SHALL have no timeout; latency is set only by mul_valid.
REQ-030 A result handshake occurs on out_valid && out_ready; it SHALL clear out_valid unless a new result loads in the same cycle.
REQ-031 If a load and a handshake fall in the same cycle, the load SHALL win and out_valid SHALL stay 1.
REQ-032 Issue gating (REQ-024) SHALL guarantee that no result is ever overwritten before it is accepted.
REQ-033 mul_valid SHALL be ignored in IDLE and ISSUE.
REQ-034 At most one multiplication SHALL be in flight at any time.
REQ-035 out_product SHALL hold its value while out_valid=1 and out_ready=0.
REQ-036 Dispatch-to-result latency SHALL be: operands at FIFO head to mul_init = 2 cycles; mul_valid to out_valid = 1 cycle.

Reset
REQ-037 reset_L=0 SHALL asynchronously force the following, regardless of state:
- state=IDLE; FIFO empty (pointers and count 0).
- in_ready=1; mul_init=0.
- mul_multiplicand=0; mul_multiplier=0.
- out_valid=0; out_product=0; busy=0.
REQ-038 Reset asserted mid-WAIT SHALL abandon the operation; a later stray mul_valid is discarded per REQ-033.
REQ-039 Deassertion of reset SHALL take effect at the first rising edge after release; no operation begins in that cycle.

Verification
REQ-040 Single op, N=64: push a=3, b=-5, out_ready=1 -> one mul_init pulse carrying 3/-5; out_product=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1 with out_valid one cycle after mul_valid.
REQ-041 Fill: push 5 pairs back-to-back with the multiplier held busy -> in_ready=0 after the 4th push; the 5th pair is held until a pop; results are returned in push order.
REQ-042 Backpressure: two ops queued, out_ready=0 -> first result held stable and no second mul_init; raise out_ready -> second mul_init within 2 cycles.
REQ-043 Extremes: -2^63 * -2^63 -> 2^126 (0x4000_0000_0000_0000_0000_0000_0000_0000); 0*x -> 0; -1*1 -> all ones.
REQ-044 Reset: pulse reset_L low asynchronously mid-WAIT with 2 entries queued -> all outputs per REQ-037 immediately, and the following mul_valid produces no out_valid.
REQ-045 Random: 1000 random operand pairs with random in_valid/out_ready, checked against a signed 2N-bit reference model -> no result mismatches, drops, or duplicates.
